// File: rtl/div_iterative_unit_pkg.sv
// Shared types and constants for the iterative signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_WIDTH   = 32;
    localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;
    localparam logic [31:0] DIV_NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_iterative_unit_if.sv
// Handshake/data bundle between multdiv control and the divider.
// DIV_REMAINDER_EN adds the signed remainder output.
interface div_iterative_unit_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
`ifdef DIV_REMAINDER_EN
        input  data_remainder,
`endif
        input  busy
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
`ifdef DIV_REMAINDER_EN
        output data_remainder,
`endif
        output busy
    );

endinterface

// File: rtl/div_iterative_unit_special_case_checker.sv
// Detects the divide cases that bypass iteration: zero divisor and INT_MIN / -1.
module div_special_case_checker
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             div_by_zero,
    output logic             div_overflow
);

    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    assign div_by_zero  = (b == '0);
    assign div_overflow = (a == INT_MIN) && (b == '1);

endmodule

// File: rtl/div_iterative_unit.sv
// Sequential signed divider: restoring shift-subtract, one quotient bit per clock.
// Optional remainder output under DIV_REMAINDER_EN.
module div_iterative_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input logic                 clock,
    input logic                 reset_n,
    div_iterative_unit_if.slave bus
);

    // Magnitude is taken as unsigned, so |INT_MIN| stays representable.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    div_state_t       state, state_n;
    logic [WIDTH-1:0] rem, q, divisor;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic [WIDTH-1:0] result_r;
    logic             exception_r;
    logic             div_by_zero, div_overflow;
    logic [WIDTH:0]   shifted, trial;
    logic             trial_neg;
`ifdef DIV_REMAINDER_EN
    logic             sign_a;
    logic [WIDTH-1:0] remainder_r;
`endif

    div_special_case_checker #(.WIDTH(WIDTH)) u_special (
        .a            (bus.data_operandA),
        .b            (bus.data_operandB),
        .div_by_zero  (div_by_zero),
        .div_overflow (div_overflow)
    );

    assign shifted   = {rem, q[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign trial_neg = trial[WIDTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // A start pulse wins in every state: aborted work never reaches DONE.
    always_comb begin
        state_n            = state;
        bus.busy           = 1'b0;
        bus.data_resultRDY = 1'b0;
        if (bus.ctrl_DIV) begin
            state_n = (div_by_zero || div_overflow) ? DONE : RUN;
        end else begin
            unique case (state)
                IDLE: state_n = IDLE;
                RUN:  state_n = (cnt == CNT_W'(WIDTH-1)) ? FIX : RUN;
                FIX:  state_n = DONE;
                DONE: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
        unique case (state)
            RUN, FIX: bus.busy = 1'b1;
            DONE:     bus.data_resultRDY = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem         <= '0;
            q           <= '0;
            divisor     <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            result_r    <= '0;
            exception_r <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_a      <= 1'b0;
            remainder_r <= '0;
`endif
        end else if (bus.ctrl_DIV) begin
            if (div_by_zero) begin
                result_r    <= '0;
                exception_r <= 1'b1;
`ifdef DIV_REMAINDER_EN
                remainder_r <= bus.data_operandA;
`endif
            end else if (div_overflow) begin
                result_r    <= bus.data_operandA;
                exception_r <= 1'b1;
`ifdef DIV_REMAINDER_EN
                remainder_r <= '0;
`endif
            end else begin
                q       <= abs_mag(bus.data_operandA);
                divisor <= abs_mag(bus.data_operandB);
                rem     <= '0;
                cnt     <= '0;
                sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
`ifdef DIV_REMAINDER_EN
                sign_a  <= bus.data_operandA[WIDTH-1];
`endif
            end
        end else if (state == RUN) begin
            rem <= trial_neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], ~trial_neg};
            cnt <= cnt + 1'b1;
        end else if (state == FIX) begin
            result_r    <= apply_sign(q, sign_q);
            exception_r <= 1'b0;
`ifdef DIV_REMAINDER_EN
            remainder_r <= apply_sign(rem, sign_a);
`endif
        end
    end

    assign bus.data_result    = result_r;
    assign bus.data_exception = exception_r;
`ifdef DIV_REMAINDER_EN
    assign bus.data_remainder = remainder_r;
`endif

endmodule

// File: doc/div_iterative_unit.md
Name: div_iterative_unit

Overview:
- Sequential signed integer divider; the division-side counterpart of the multiplier in the MultDiv unit.
- Started by a one-cycle `ctrl_DIV` pulse from the processor's multdiv control.
- Computes a truncating quotient with a restoring shift-subtract algorithm, one quotient bit per clock.
- Flags divide-by-zero and the single overflow case, `INT_MIN / -1`, on the `data_exception` output.

Parameters:
- `WIDTH`, 32, operand and result width in bits; the iteration count equals `WIDTH`.
- `CNT_W`, 6, iteration counter width; must satisfy `2**CNT_W > WIDTH`.

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ctrl_DIV`  in  1  start pulse; operands are sampled on the same edge
- `data_operandA`  in  `WIDTH`  dividend, two's complement
- `data_operandB`  in  `WIDTH`  divisor, two's complement
- `data_result`  out  `WIDTH`  quotient; held until the next start
- `data_exception`  out  1  error flag; valid while `data_resultRDY` is high, held afterwards
- `data_resultRDY`  out  1  one-cycle completion pulse
- `busy`  out  1  high while a division is in progress

Behaviour:
- Reset (async assert, sync release): state IDLE; `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0; counter and working registers cleared.
- Reset mid-operation aborts immediately. No `data_resultRDY` is issued for the aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE: on an edge with `ctrl_DIV`=1, latch the operands and check the special cases on the raw operands.
  - Divisor = 0: go to DONE; `data_result`=0, `data_exception`=1.
  - A = 0x80000000 (`1<<(WIDTH-1)`) and B = all-ones: go to DONE; `data_result`=0x80000000, `data_exception`=1.
  - Otherwise: go to RUN. Load |A| into the quotient register, |B| into the divisor register, remainder=0, count=0, and store `sign_q` = A[MSB] ^ B[MSB].
- RUN, each edge:
  - Shift {rem, q} left by 1.
  - trial = rem_shifted - divisor, computed at `WIDTH+1` bits.
  - If trial ≥ 0: rem = trial and the q LSB = 1. Otherwise keep rem and the q LSB = 0.
  - count++. Go to FIX after the edge with count = `WIDTH-1` (`WIDTH` iterations in total).
- Magnitude of INT_MIN: |0x80000000| is treated as unsigned 0x80000000. The magnitude path is `WIDTH` bits unsigned, so no overflow occurs.
- FIX: `data_result` = `sign_q` ? -q : q; `data_exception`=0; go to DONE.
- DONE: `data_resultRDY`=1 for exactly this cycle; go to IDLE on the next edge.
- Latency, counting from start edge E0:
  - Special case: `data_resultRDY` is high in the cycle after E0.
  - Normal case: `WIDTH` RUN edges (E1..E32) and the FIX edge (E33); `data_resultRDY` is high in the cycle after E33. This is 34 cycles from start to the ready cycle when `WIDTH`=32.
- `busy`=1 in RUN and FIX; 0 in IDLE and DONE.
- `ctrl_DIV` in DONE behaves as in IDLE: a new operation starts and the ready pulse is still seen for that cycle.
- `ctrl_DIV` during RUN or FIX aborts the current operation and restarts with the new operands. No ready pulse is issued for the aborted operation.
- `data_result`/`data_exception` change only on FIX or on special-case entry. Operand changes while busy have no effect.
- Dividend 0 with a nonzero divisor follows the normal path and gives result 0, exception 0.

Optional Feature:
- Macro `DIV_REMAINDER_EN`.
- Defined:
  - Adds output port `data_remainder` (`WIDTH` bits).
  - Written in FIX as `sign_a` ? -rem : rem, where `sign_a` is the latched sign of A (remainder carries the dividend's sign).
  - Special cases: divide-by-zero gives A; overflow gives 0. Reset value 0.
- Undefined: the port is absent and no remainder sign-fix logic is generated. The quotient behaviour is identical in both builds.

Decomposition:
- Package `div_pkg`: state enum (IDLE, RUN, FIX, DONE), `DIV_INT_MIN`, `DIV_NEG_ONE`, and the default `WIDTH`.
- Sub-module `div_special_case_checker` (combinational):
  - Inputs A, B.
  - Outputs `div_by_zero` and `div_overflow`.
  - Mirrors the multiplier-side special-case detection.

Test Plan:
- A=100, B=7 → ready 34 cycles after start; result=14, exception=0; remainder=2 if enabled.
- A=-100 (0xFFFFFF9C), B=7 → result=-14 (0xFFFFFFF2); remainder=-2 if enabled.
- A=0x80000000, B=0xFFFFFFFF → ready in the next cycle; result=0x80000000, exception=1, `busy` never high.
- A=5, B=0 → ready in the next cycle; result=0, exception=1; remainder=5 if enabled.
- Start A=1000, B=3; at cycle 10 re-pulse `ctrl_DIV` with A=-9, B=2 → single ready pulse 34 cycles after the second start; result=-4 (0xFFFFFFFC).
- Start A=50, B=5; assert `reset_n`=0 at cycle 20 → all outputs 0 immediately and no ready pulse; after release, A=50, B=5 gives result=10.
